// File: rtl/rdyacpt_pkg.sv
// Shared definitions for the rdy/acpt round-robin arbiter.
//   idw_f     : index width for n requesters, never less than 1 bit
//   req_idx_t : requester index type for the default configuration
package rdyacpt_pkg;

    function automatic int idw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    typedef logic [idw_f(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/rdyacpt_rr_pick.sv
// Combinational rotate-priority picker.
//   req     : request vector
//   ptr     : highest-priority index (search starts here and wraps)
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of granted requester
//   any     : at least one request present
module rdyacpt_rr_pick
    import rdyacpt_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = idw_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // ptr is always < NUM_REQ, so one subtraction wraps correctly
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rdyacpt_rr_arbiter.sv
// Round-robin arbiter sharing one rdy/acpt downstream channel between
// NUM_REQ rdy/acpt requesters, with per-requester burst lock and a
// registered output stage.
//   clk, reset_n : clock, async active-low reset
//   rdy_di       : per-requester data valid
//   data_di      : per-requester data, requester i at [i*WIDTH +: WIDTH]
//   lock_di      : per-requester burst lock, sampled with its transfer
//   acpt_di      : per-requester accept (one-hot or zero)
//   rdy_do       : output register full
//   data_do      : output data
//   src_do       : requester that supplied data_do
//   acpt_do      : downstream accept
module rdyacpt_rr_arbiter
    import rdyacpt_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       rdy_di,
    input  logic [NUM_REQ*WIDTH-1:0] data_di,
    input  logic [NUM_REQ-1:0]       lock_di,
    output logic [NUM_REQ-1:0]       acpt_di,
    output logic                     rdy_do,
    output logic [WIDTH-1:0]         data_do,
    output logic [idw_f(NUM_REQ)-1:0] src_do,
    input  logic                     acpt_do
);

    localparam int IDW = idw_f(NUM_REQ);

    logic [IDW-1:0]     ptr;
    logic               locked;
    logic [IDW-1:0]     owner;

    logic               free;
    logic [NUM_REQ-1:0] own_mask;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               any;
    logic               up_xfer;

    // Output slot can take a word when empty or being drained this cycle.
    assign free = !rdy_do || acpt_do;

    always_comb begin
        own_mask        = '0;
        own_mask[owner] = 1'b1;
    end

    // While locked only the owner may win, even if it is idle.
    assign elig = locked ? (rdy_di & own_mask) : rdy_di;

    rdyacpt_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Gated by reset_n so no accept leaks out while reset is held.
    assign up_xfer = free && any && reset_n;
    assign acpt_di = up_xfer ? gnt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_do  <= 1'b0;
            data_do <= '0;
            src_do  <= '0;
            ptr     <= '0;
            locked  <= 1'b0;
            owner   <= '0;
        end else if (up_xfer) begin
            rdy_do  <= 1'b1;
            data_do <= data_di[gnt_idx*WIDTH +: WIDTH];
            src_do  <= gnt_idx;
            ptr     <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            locked  <= lock_di[gnt_idx];
            if (lock_di[gnt_idx]) owner <= gnt_idx;
        end else if (acpt_do) begin
            rdy_do  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rdyacpt_rr_arbiter.sv
module tb_rdyacpt_rr_arbiter;
    import rdyacpt_pkg::*;

    localparam int NR = 4;
    localparam int W  = 8;

    logic                clk;
    logic                reset_n;
    logic [NR-1:0]       rdy_di;
    logic [NR*W-1:0]     data_di;
    logic [NR-1:0]       lock_di;
    logic [NR-1:0]       acpt_di;
    logic                rdy_do;
    logic [W-1:0]        data_do;
    req_idx_t            src_do;
    logic                acpt_do;

    rdyacpt_rr_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rdy_di  (rdy_di),
        .data_di (data_di),
        .lock_di (lock_di),
        .acpt_di (acpt_di),
        .rdy_do  (rdy_do),
        .data_do (data_do),
        .src_do  (src_do),
        .acpt_do (acpt_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // handshake rules on both sides
    for (genvar i = 0; i < NR; i++) begin : g_up
        a_up_hold: assert property (@(posedge clk) disable iff (!reset_n)
            rdy_di[i] && !acpt_di[i] |=> rdy_di[i] && $stable(data_di[i*W +: W]));
    end
    a_dn_hold: assert property (@(posedge clk) disable iff (!reset_n)
        rdy_do && !acpt_do |=> rdy_do && $stable(data_do) && $stable(src_do));
    a_onehot: assert property (@(posedge clk) $onehot0(acpt_di));

    int nchk  = 0;
    int npass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    endtask

    // reference model: abstract arbiter state
    int         m_ptr, m_owner;
    bit         m_locked, m_rdy;
    logic [7:0] m_data;
    int         m_src;
    logic [NR-1:0] last_acpt;

    task automatic m_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0; m_rdy = 0; m_data = 0; m_src = 0;
    endtask

    function automatic int model_pick();
        if (m_rdy && !acpt_do) return -1;
        if (m_locked) return rdy_di[m_owner] ? m_owner : -1;
        for (int k = 0; k < NR; k++)
            if (rdy_di[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction

    // one clock: check accept before the edge, registered outputs after it
    task automatic step();
        int g;
        logic [NR-1:0] e;
        @(negedge clk);
        g = model_pick();
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        chk("acpt_di", 32'(acpt_di), 32'(e));
        last_acpt = acpt_di;
        if (g >= 0) begin
            m_rdy  = 1;
            m_data = data_di[g*W +: W];
            m_src  = g;
            m_ptr  = (g + 1) % NR;
            if (lock_di[g]) begin m_locked = 1; m_owner = g; end
            else m_locked = 0;
        end else if (acpt_do) m_rdy = 0;
        @(posedge clk); #1;
        chk("rdy_do", 32'(rdy_do), 32'(m_rdy));
        chk("data_do", 32'(data_do), 32'(m_data));
        chk("src_do", 32'(src_do), 32'(m_src));
    endtask

    task automatic do_reset();
        rdy_di = '0; lock_di = '0; acpt_do = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_rdy_do", 32'(rdy_do), 32'd0);
        chk("rst_acpt_di", 32'(acpt_di), 32'd0);
        m_reset();
        @(posedge clk); #2 reset_n = 1'b1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        data_di[i*W +: W] = d;
    endtask

    logic [NR-1:0] p_rdy;

    initial begin
        reset_n = 1'b0; rdy_di = '0; lock_di = '0; acpt_do = 1'b0; data_di = '0;
        last_acpt = '0;
        m_reset();
        #3;
        chk("reset_data_do", 32'(data_do), 32'd0);
        chk("reset_src_do", 32'(src_do), 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;

        // single requester
        rdy_di = 4'b0001; set_data(0, 8'hA5); acpt_do = 1'b1;
        step();
        chk("t1_acpt", 32'(last_acpt), 32'h1);
        chk("t1_data", 32'(data_do), 32'hA5);
        chk("t1_src", 32'(src_do), 32'd0);
        rdy_di = '0;
        do_reset();

        // round robin over all four
        for (int i = 0; i < NR; i++) set_data(i, 8'(8'h10 + i));
        rdy_di = 4'b1111; acpt_do = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t2_src", 32'(src_do), 32'(n % NR));
            chk("t2_data", 32'(data_do), 32'(8'h10 + (n % NR)));
        end
        do_reset();

        // backpressure
        for (int i = 0; i < NR; i++) set_data(i, 8'(8'h20 + i));
        rdy_di = 4'b1111; acpt_do = 1'b1;
        step();
        acpt_do = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t3_hold_acpt", 32'(last_acpt), 32'd0);
            chk("t3_hold_src", 32'(src_do), 32'd0);
            chk("t3_hold_data", 32'(data_do), 32'h20);
        end
        acpt_do = 1'b1;
        step();
        chk("t3_resume_acpt", 32'(last_acpt), 32'h2);
        chk("t3_resume_data", 32'(data_do), 32'h21);
        do_reset();

        // lock burst from requester 1
        acpt_do = 1'b1;
        rdy_di = 4'b0001; set_data(0, 8'h30);
        step();
        for (int i = 0; i < NR; i++) set_data(i, 8'(8'h40 + i));
        rdy_di = 4'b0111; lock_di = 4'b0010;
        step(); chk("t4_src_a", 32'(src_do), 32'd1);
        step(); chk("t4_src_b", 32'(src_do), 32'd1);
        lock_di = 4'b0000;
        step(); chk("t4_src_c", 32'(src_do), 32'd1);
        rdy_di = 4'b0101;
        step(); chk("t4_src_d", 32'(src_do), 32'd2);
        rdy_di = 4'b0001;
        step(); chk("t4_src_e", 32'(src_do), 32'd0);
        rdy_di = '0;
        do_reset();

        // locked owner idle blocks others
        acpt_do = 1'b1;
        rdy_di = 4'b0010; lock_di = 4'b0010; set_data(1, 8'h51);
        step();
        rdy_di = 4'b0001; lock_di = '0; set_data(0, 8'h50);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t5_blocked", 32'(last_acpt), 32'd0);
        end
        rdy_di = 4'b0011; set_data(1, 8'h52);
        step(); chk("t5_owner", 32'(src_do), 32'd1);
        rdy_di = 4'b0001;
        step(); chk("t5_after", 32'(src_do), 32'd0);
        do_reset();

        // reset in the middle of a held transfer
        rdy_di = 4'b0001; set_data(0, 8'h33); acpt_do = 1'b0;
        step();
        rdy_di = 4'b0001; set_data(0, 8'h34);
        step();
        chk("t6_held", 32'(rdy_do), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_rdy", 32'(rdy_do), 32'd0);
        chk("t6_async_acpt", 32'(acpt_di), 32'd0);
        m_reset();
        rdy_di = 4'b0100; set_data(2, 8'h44);
        @(posedge clk); #2 reset_n = 1'b1;
        acpt_do = 1'b1;
        step();
        chk("t6_src", 32'(src_do), 32'd2);
        chk("t6_data", 32'(data_do), 32'h44);
        rdy_di = '0;
        do_reset();

        // random traffic against the model
        p_rdy = '0; last_acpt = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (p_rdy[i] && last_acpt[i]) p_rdy[i] = 1'($urandom_range(0, 1));
                else if (!p_rdy[i]) p_rdy[i] = ($urandom_range(0, 2) == 0);
                else continue;
                if (p_rdy[i]) begin
                    set_data(i, 8'($urandom));
                    lock_di[i] = ($urandom_range(0, 3) == 0);
                end
            end
            rdy_di  = p_rdy;
            acpt_do = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
